float_issue_scoreboard: RTL

- Sits directly downstream of the FP decode stage and consumes its f_decode_s control bits together with the instruction's register fields.
- Tracks FP registers with in-flight long-latency writes: FAM arithmetic ops and FP loads. Also counts outstanding FAM ops and outstanding fflags writers.
- Produces the issue-ready signal that the FP pipeline uses to stall on RAW, WAW, capacity and FCSR-ordering hazards.

---
 rtl/float_issue_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/float_issue_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | float_issue_scoreboard : FP issue hazard tracking for FAM ops and loads  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module float_issue_scoreboard #(
   parameter int reg_els_p              = 32,
   parameter int max_fam_outstanding_p  = 4,
   parameter int max_load_outstanding_p = 8
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic                                      issue_v_i,
   input  logic [$clog2(reg_els_p)-1:0]              rs1_i,
   input  logic [$clog2(reg_els_p)-1:0]              rs2_i,
   input  logic [$clog2(reg_els_p)-1:0]              rs3_i,
   input  logic [$clog2(reg_els_p)-1:0]              rd_i,
   input  logic                                      op_reads_frf1_i,
   input  logic                                      op_reads_frf2_i,
   input  logic                                      op_reads_frf3_i,
   input  logic                                      op_writes_frf_i,
   input  logic                                      is_fam_op_i,
   input  logic                                      is_load_op_i,
   input  logic                                      is_fcsr_op_i,
   input  logic                                      op_writes_fflags_i,
   input  logic                                      issue_accept_i,
   input  logic                                      fam_wb_v_i,
   input  logic [$clog2(reg_els_p)-1:0]              fam_wb_rd_i,
   input  logic                                      fam_wb_fflags_i,
   input  logic                                      load_wb_v_i,
   input  logic [$clog2(reg_els_p)-1:0]              load_wb_rd_i,
   output logic                                      issue_ready_o,
   output logic [reg_els_p-1:0]                      busy_o,
   output logic [$clog2(max_fam_outstanding_p+1)-1:0] fam_pending_o,
   output logic                                      drained_o
);

   localparam int c_fam_w = $clog2(max_fam_outstanding_p + 1);
   localparam int c_ld_w  = $clog2(max_load_outstanding_p + 1);

   localparam logic [c_fam_w-1:0] c_fam_max = c_fam_w'(max_fam_outstanding_p);
   localparam logic [c_ld_w-1:0]  c_ld_max  = c_ld_w'(max_load_outstanding_p);
   localparam logic [c_fam_w-1:0] c_fam_one = c_fam_w'(1);
   localparam logic [c_ld_w-1:0]  c_ld_one  = c_ld_w'(1);

   logic [reg_els_p-1:0] busy_q, busy_d;
   logic [c_fam_w-1:0]   fam_cnt_q, fam_cnt_d;
   logic [c_fam_w-1:0]   ff_cnt_q, ff_cnt_d;
   logic [c_ld_w-1:0]    load_cnt_q, load_cnt_d;

   logic                 w_hazard;
   logic                 w_fire;
   logic                 w_fam_inc, w_ff_inc, w_ld_inc;
   logic                 w_fam_dec, w_ff_dec, w_ld_dec;
   logic [reg_els_p-1:0] w_set_mask, w_clr_mask;

   assign w_hazard = (op_reads_frf1_i & busy_q[rs1_i])
                   | (op_reads_frf2_i & busy_q[rs2_i])
                   | (op_reads_frf3_i & busy_q[rs3_i])
                   | (op_writes_frf_i & busy_q[rd_i])
                   | (is_fam_op_i     & (fam_cnt_q == c_fam_max))
                   | (is_load_op_i    & (load_cnt_q == c_ld_max))
                   | (is_fcsr_op_i    & (ff_cnt_q != '0));

   assign issue_ready_o = issue_v_i & ~reset_i & ~w_hazard;

   // An accept without ready is illegal; gating by ready keeps state untouched.
   assign w_fire    = issue_v_i & issue_accept_i & issue_ready_o;
   assign w_fam_inc = w_fire & is_fam_op_i;
   assign w_ff_inc  = w_fam_inc & op_writes_fflags_i;
   assign w_ld_inc  = w_fire & is_load_op_i;

   // Writebacks to idle registers or empty counters are dropped to avoid wrap.
   assign w_fam_dec = fam_wb_v_i & busy_q[fam_wb_rd_i] & (fam_cnt_q != '0);
   assign w_ff_dec  = w_fam_dec & fam_wb_fflags_i & (ff_cnt_q != '0);
   assign w_ld_dec  = load_wb_v_i & busy_q[load_wb_rd_i] & (load_cnt_q != '0);

   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (w_fire & (is_fam_op_i | is_load_op_i) & op_writes_frf_i) w_set_mask[rd_i] = 1'b1;
      if (w_fam_dec) w_clr_mask[fam_wb_rd_i]  = 1'b1;
      if (w_ld_dec)  w_clr_mask[load_wb_rd_i] = 1'b1;
      busy_d = (busy_q & ~w_clr_mask) | w_set_mask;

      fam_cnt_d = fam_cnt_q;
      if (w_fam_inc & ~w_fam_dec)      fam_cnt_d = fam_cnt_q + c_fam_one;
      else if (~w_fam_inc & w_fam_dec) fam_cnt_d = fam_cnt_q - c_fam_one;

      ff_cnt_d = ff_cnt_q;
      if (w_ff_inc & ~w_ff_dec)        ff_cnt_d = ff_cnt_q + c_fam_one;
      else if (~w_ff_inc & w_ff_dec)   ff_cnt_d = ff_cnt_q - c_fam_one;

      load_cnt_d = load_cnt_q;
      if (w_ld_inc & ~w_ld_dec)        load_cnt_d = load_cnt_q + c_ld_one;
      else if (~w_ld_inc & w_ld_dec)   load_cnt_d = load_cnt_q - c_ld_one;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q     <= '0;
         fam_cnt_q  <= '0;
         ff_cnt_q   <= '0;
         load_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         fam_cnt_q  <= fam_cnt_d;
         ff_cnt_q   <= ff_cnt_d;
         load_cnt_q <= load_cnt_d;
      end
   end

   assign busy_o        = busy_q;
   assign fam_pending_o = fam_cnt_q;
   assign drained_o     = (fam_cnt_q == '0) & (load_cnt_q == '0);

   a_accept_ready: assert property (@(posedge clk_i) disable iff (reset_i)
      issue_accept_i |-> issue_ready_o);
   a_fam_wb_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      fam_wb_v_i |-> (busy_q[fam_wb_rd_i] && (fam_cnt_q != '0)));
   a_ff_wb_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      (fam_wb_v_i && fam_wb_fflags_i) |-> (ff_cnt_q != '0));
   a_ld_wb_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      load_wb_v_i |-> (busy_q[load_wb_rd_i] && (load_cnt_q != '0)));

endmodule
`default_nettype wire
